motor_pwm_ramp: RTL and testbench

Slew-rate limiter for the two GoPiGo wheel PWM commands, placed directly upstream of the SPI controller's `motor_pwm_left_i` / `motor_pwm_rght_i` inputs. Application logic writes raw signed targets. This block moves each registered output toward its target by one PWM unit per tick, so a step command never reaches the motors as a step. It also provides:
- an emergency stop;
- a one-cycle update strobe, so the SPI sequencer can schedule a resend.

---
 rtl/motor_pkg.sv | 25 ++
 rtl/pwm_ramp_chan.sv | 50 +++++
 rtl/motor_pwm_ramp.sv | 71 +++++++
 tb/tb_motor_pwm_ramp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared types and constants for the wheel PWM slew limiter.
// clamp_pwm saturates a signed command to +/-lim using one extra bit of headroom.
package motor_pkg;

  localparam int PWM_W           = 8;
  localparam int PWM_MAX_DEF     = 100;
  localparam int STEP_CYCLES_DEF = 120000;

  typedef logic signed [PWM_W-1:0] pwm_t;
  typedef logic signed [PWM_W:0]   pwm_ext_t;

  function automatic pwm_t clamp_pwm(input pwm_t v, input pwm_ext_t lim);
    pwm_ext_t v_ext;
    pwm_ext_t neg_lim;
    v_ext   = {v[PWM_W-1], v};
    neg_lim = -lim;
    if (v_ext > lim)
      return lim[PWM_W-1:0];
    else if (v_ext < neg_lim)
      return neg_lim[PWM_W-1:0];
    else
      return v;
  endfunction

endpackage

// File: rtl/pwm_ramp_chan.sv
// One ramped PWM channel: clamps the target and steps the registered output by +/-1 per tick.
// changed flags that the value loaded on the coming edge differs from the current one.
module pwm_ramp_chan
  import motor_pkg::*;
#(
  parameter int PWM_MAX = PWM_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic estop,
  input  pwm_t tgt,
  output pwm_t pwm,
  output logic changed
);

  localparam pwm_ext_t LIM = pwm_ext_t'(PWM_MAX);

  pwm_t     tgt_c;
  pwm_t     pwm_nxt;
  pwm_ext_t cur_ext;
  pwm_ext_t tgt_ext;
  pwm_ext_t nxt_ext;

  // The output is always within +/-LIM and the target is clamped, so +/-1 cannot wrap.
  always_comb begin
    tgt_c   = clamp_pwm(tgt, LIM);
    cur_ext = {pwm[PWM_W-1], pwm};
    tgt_ext = {tgt_c[PWM_W-1], tgt_c};
    nxt_ext = cur_ext;
    if (estop) begin
      nxt_ext = '0;
    end else if (tick) begin
      if (cur_ext < tgt_ext)
        nxt_ext = cur_ext + pwm_ext_t'(1);
      else if (cur_ext > tgt_ext)
        nxt_ext = cur_ext - pwm_ext_t'(1);
    end
    pwm_nxt = nxt_ext[PWM_W-1:0];
    changed = (pwm_nxt != pwm);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pwm <= '0;
    else
      pwm <= pwm_nxt;
  end

endmodule

// File: rtl/motor_pwm_ramp.sv
// Slew-rate limiter for the left/right wheel PWM commands feeding the SPI controller.
// Owns the shared ramp tick counter, the update strobe and the at-target compare.
module motor_pwm_ramp
  import motor_pkg::*;
#(
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  parameter int PWM_MAX     = PWM_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  pwm_t tgt_left_i,
  input  pwm_t tgt_rght_i,
  input  logic estop_i,
  output pwm_t pwm_left_o,
  output pwm_t pwm_rght_o,
  output logic upd_o,
  output logic at_tgt_o
);

  localparam int                CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam pwm_ext_t          LIM      = pwm_ext_t'(PWM_MAX);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             chg_left;
  logic             chg_rght;

  assign tick = (cnt == CNT_LAST);

  // Estop parks the counter at 0 so the first step after release is a full period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (estop_i || tick)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  pwm_ramp_chan #(.PWM_MAX(PWM_MAX)) u_chan_left (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .estop   (estop_i),
    .tgt     (tgt_left_i),
    .pwm     (pwm_left_o),
    .changed (chg_left)
  );

  pwm_ramp_chan #(.PWM_MAX(PWM_MAX)) u_chan_rght (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .estop   (estop_i),
    .tgt     (tgt_rght_i),
    .pwm     (pwm_rght_o),
    .changed (chg_rght)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      upd_o <= 1'b0;
    else
      upd_o <= chg_left | chg_rght;
  end

  assign at_tgt_o = (pwm_left_o == clamp_pwm(tgt_left_i, LIM)) &&
                    (pwm_rght_o == clamp_pwm(tgt_rght_i, LIM));

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// Scoreboard bench for motor_pwm_ramp with STEP_CYCLES=4: each expected upd_o pulse
// (edge number after reset release, left, right) is queued; a monitor pops on every pulse.
module tb_motor_pwm_ramp;

  localparam int STEP = 4;
  localparam int PMAX = 100;

  typedef struct {
    int edge_no;
    int left;
    int right;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              estop = 1'b0;
  logic signed [7:0] tgt_l = '0;
  logic signed [7:0] tgt_r = '0;
  logic signed [7:0] pwm_l;
  logic signed [7:0] pwm_r;
  logic              upd;
  logic              at_tgt;

  int   edge_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  motor_pwm_ramp #(.STEP_CYCLES(STEP), .PWM_MAX(PMAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tgt_left_i (tgt_l),
    .tgt_rght_i (tgt_r),
    .estop_i    (estop),
    .pwm_left_o (pwm_l),
    .pwm_rght_o (pwm_r),
    .upd_o      (upd),
    .at_tgt_o   (at_tgt)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      edge_n <= 0;
    else
      edge_n <= edge_n + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic push(input int e, input int l, input int r);
    exp_t x;
    x.edge_no = e;
    x.left    = l;
    x.right   = r;
    sb.push_back(x);
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  task automatic do_reset(input int l, input int r);
    rst_n = 1'b0;
    estop = 1'b0;
    tgt_l = 8'(l);
    tgt_r = 8'(r);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every upd_o pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && upd) begin
      if (sb.size() == 0) begin
        check("upd_unexpected", 1, 0);
      end else begin
        cur = sb.pop_front();
        check("upd_edge", edge_n, cur.edge_no);
        check("upd_left", int'(pwm_l), cur.left);
        check("upd_rght", int'(pwm_r), cur.right);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    // Reset with zero targets
    @(negedge clk);
    check("rst_left", int'(pwm_l), 0);
    check("rst_rght", int'(pwm_r), 0);
    check("rst_upd", int'(upd), 0);
    check("rst_at_tgt", int'(at_tgt), 1);
    rst_n = 1'b1;
    wait_edge(12);
    check("idle_left", int'(pwm_l), 0);
    check("idle_at_tgt", int'(at_tgt), 1);
    check("idle_sb_empty", sb.size(), 0);

    // Left +5 from reset: steps at edges 4..20
    do_reset(5, 0);
    check("up_at_tgt_start", int'(at_tgt), 0);
    for (int k = 1; k <= 5; k++) push(STEP * k, k, 0);
    wait_edge(19);
    check("up_at_tgt_19", int'(at_tgt), 0);
    wait_edge(20);
    check("up_at_tgt_20", int'(at_tgt), 1);
    check("up_left_20", int'(pwm_l), 5);
    check("up_rght_20", int'(pwm_r), 0);
    wait_edge(26);
    check("up_sb_empty", sb.size(), 0);

    // Reversal +3 -> -2 through zero
    do_reset(3, 0);
    push(4, 1, 0);  push(8, 2, 0);   push(12, 3, 0);
    push(16, 2, 0); push(20, 1, 0);  push(24, 0, 0);
    push(28, -1, 0); push(32, -2, 0);
    wait_edge(14);
    tgt_l = 8'hFE;
    wait_edge(44);
    check("rev_left", int'(pwm_l), -2);
    check("rev_at_tgt", int'(at_tgt), 1);
    check("rev_sb_empty", sb.size(), 0);

    // Saturation: 8'h80 -> -100, +127 -> +100
    do_reset(-128, 127);
    check("sat_at_tgt_start", int'(at_tgt), 0);
    for (int k = 1; k <= 100; k++) push(STEP * k, -k, k);
    wait_edge(398);
    check("sat_left_398", int'(pwm_l), -99);
    check("sat_at_tgt_398", int'(at_tgt), 0);
    wait_edge(440);
    check("sat_left", int'(pwm_l), -100);
    check("sat_rght", int'(pwm_r), 100);
    check("sat_at_tgt", int'(at_tgt), 1);
    check("sat_sb_empty", sb.size(), 0);

    // Estop from +40/-40, held 10 cycles
    do_reset(40, -40);
    for (int k = 1; k <= 40; k++) push(STEP * k, k, -k);
    wait_edge(162);
    check("es_pre_left", int'(pwm_l), 40);
    push(163, 0, 0);
    estop = 1'b1;
    wait_edge(163);
    check("es_left", int'(pwm_l), 0);
    check("es_rght", int'(pwm_r), 0);
    wait_edge(172);
    estop = 1'b0;
    for (int k = 1; k <= 40; k++) push(172 + STEP * k, k, -k);
    wait_edge(175);
    check("es_hold_left", int'(pwm_l), 0);
    wait_edge(340);
    check("es_left_end", int'(pwm_l), 40);
    check("es_rght_end", int'(pwm_r), -40);
    check("es_at_tgt", int'(at_tgt), 1);
    check("es_sb_empty", sb.size(), 0);

    // Async reset mid-ramp at left = 17
    do_reset(50, 0);
    for (int k = 1; k <= 17; k++) push(STEP * k, k, 0);
    wait_edge(70);
    check("ar_pre_left", int'(pwm_l), 17);
    rst_n = 1'b0;
    #1;
    check("ar_left", int'(pwm_l), 0);
    check("ar_upd", int'(upd), 0);
    check("ar_sb_empty", sb.size(), 0);
    tgt_l = 8'sd3;
    @(negedge clk);
    rst_n = 1'b1;
    push(4, 1, 0); push(8, 2, 0); push(12, 3, 0);
    wait_edge(3);
    check("ar_restart_3", int'(pwm_l), 0);
    wait_edge(16);
    check("ar_restart_left", int'(pwm_l), 3);
    check("ar_restart_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
